// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller.
//   scan_state_t : FSM state encoding
//   MODE_*       : values of the 2-bit mode input
//   next_en      : next enabled channel after sel in the scan direction
//   last_en      : final channel of a pass in the scan direction
package mux_scan_pkg;

   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef logic [N_CH-1:0]  ch_mask_t;
   typedef logic [SEL_W-1:0] ch_sel_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      SETTLE  = 2'd2,
      CAPTURE = 2'd3
   } scan_state_t;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   // Searches sel+1, sel+2, ... (dir=0) or sel-1, sel-2, ... (dir=1) with
   // wrap. The eighth probe lands back on sel, so a lone enabled channel
   // re-selects itself; an empty mask leaves sel unchanged.
   function automatic ch_sel_t next_en(input ch_sel_t sel, input ch_mask_t mask,
                                       input logic dir);
      ch_sel_t idx;
      logic    found;
      next_en = sel;
      found   = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = dir ? (sel - SEL_W'(k)) : (sel + SEL_W'(k));
         if (!found && mask[idx]) begin
            next_en = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Highest enabled index when scanning up (dir=0), lowest when down.
   function automatic ch_sel_t last_en(input ch_mask_t mask, input logic dir);
      last_en = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!dir && mask[i])
            last_en = SEL_W'(i);
         if (dir && mask[N_CH-1-i])
            last_en = SEL_W'(N_CH-1-i);
      end
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-rate prescaler: counts 0..DIV-1 while run is high and wraps.
//   clk   : system clock
//   clear : async active-low reset, count returns to 0
//   run   : count enable; count is frozen while low
//   tick  : high in the cycle the count equals DIV-1 (gated by run)
module scan_tick_gen #(
   parameter int DIV = 50000000
) (
   input  logic clk,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
   end

   assign tick = run && (cnt == TC);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scheduler for the 8-to-1 switch mux: steps select on prescaler ticks or
// step requests, waits for the mux to settle, captures mux_out and builds a
// per-frame snapshot of the enabled channels.
//   clk, clear     : clock, async active-low reset
//   run            : 1 operate, 0 pause (prescaler and FSM frozen)
//   mode           : 00 up, 01 down, 10 single-step, 11 hold on sel_force
//   ch_en          : channel enable mask
//   step_req       : step pulse for mode 10
//   sel_force      : channel used in mode 11
//   mux_out        : mux data return
//   select         : registered mux select
//   sample_valid   : pulse, sample_q / sample_ch updated
//   sample_q/_ch   : captured value and its channel
//   frame_q        : last captured value per channel, disabled bits read 0
//   frame_done     : pulse with the capture that ends a pass
//   no_ch          : no channel enabled in a scanning mode
//
// state   | meaning
// IDLE    | parked, no enabled channel (scanning modes) or first cycle out of reset
// WAIT    | waiting for tick / step_req
// SETTLE  | select just changed, mux output settling
// CAPTURE | last settle cycle; mux_out captured at the closing edge
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DIV        = 50000000,
   parameter int SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       run,
   input  logic [1:0] mode,
   input  logic [7:0] ch_en,
   input  logic       step_req,
   input  logic [2:0] sel_force,
   input  logic       mux_out,
   output logic [2:0] select,
   output logic       sample_valid,
   output logic       sample_q,
   output logic [2:0] sample_ch,
   output logic [7:0] frame_q,
   output logic       frame_done,
   output logic       no_ch
);

   // CAPTURE accounts for the last settle cycle, so SETTLE holds for
   // SETTLE_CYC-1 cycles and is skipped entirely when SETTLE_CYC is 1.
   localparam int             SCW       = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SCW-1:0] SETTLE_LD = (SETTLE_CYC >= 2) ? SCW'(SETTLE_CYC - 2) : '0;

   scan_state_t    state;
   logic [SCW-1:0] settle_cnt;
   logic [1:0]     scan_mode;
   logic [7:0]     frame_r;
   logic           tick;
   logic           trig;
   logic           need_ch;
   logic [2:0]     new_sel;

   scan_tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .clear (clear),
      .run   (run),
      .tick  (tick)
   );

   assign trig    = (mode == MODE_STEP) ? step_req : tick;
   assign need_ch = (mode != MODE_HOLD);
   assign frame_q = frame_r & ch_en;

   always_comb begin
      new_sel = select;
      case (mode)
         MODE_UP, MODE_STEP: new_sel = next_en(select, ch_en, 1'b0);
         MODE_DOWN:          new_sel = next_en(select, ch_en, 1'b1);
         default:            new_sel = sel_force;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state        <= IDLE;
         select       <= '0;
         sample_q     <= 1'b0;
         sample_ch    <= '0;
         frame_r      <= '0;
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;
         no_ch        <= 1'b0;
         settle_cnt   <= '0;
         scan_mode    <= MODE_UP;
      end else begin
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;
         if (run) begin
            case (state)
               IDLE: begin
                  if (need_ch && (ch_en == '0)) begin
                     no_ch <= 1'b1;
                  end else begin
                     no_ch <= 1'b0;
                     state <= WAIT;
                  end
               end
               WAIT: begin
                  if (need_ch && (ch_en == '0)) begin
                     no_ch <= 1'b1;
                     state <= IDLE;
                  end else if (trig) begin
                     select     <= new_sel;
                     scan_mode  <= mode;
                     settle_cnt <= SETTLE_LD;
                     state      <= (SETTLE_CYC > 1) ? SETTLE : CAPTURE;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == '0)
                     state <= CAPTURE;
                  else
                     settle_cnt <= settle_cnt - 1'b1;
               end
               CAPTURE: begin
                  sample_q        <= mux_out;
                  sample_ch       <= select;
                  frame_r[select] <= mux_out;
                  sample_valid    <= 1'b1;
                  // Pass end is judged with the mode that launched this capture.
                  frame_done      <= (scan_mode != MODE_HOLD) &&
                                     (select == last_en(ch_en, scan_mode == MODE_DOWN));
                  state           <= WAIT;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
